video_pattern_gen: RTL and testbench

VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

---
 rtl/video_pattern_gen.sv | 251 +++++++++++++++++++++++++
 tb/tb_video_pattern_gen.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/video_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : video_pattern_gen
// Purpose  : Raster timing generator with test patterns: colour bars, a
//            bitmap window fed from an external synchronous ROM, bitmap over
//            bars, and a 64-pixel grid. Counter state (S0) feeds a register
//            stage (S1) that waits for the ROM; the output register (S2)
//            merges rom_data with the carried flags. Latency is 2 clocks.
// Ports    : pixel_clk   - pixel clock, sole clock
//            sys_rst_n   - asynchronous active-low reset
//            mode        - pattern select, sampled once per frame at (0,0)
//            rom_addr    - bitmap ROM address (registered counter)
//            rom_data    - ROM q, valid one clock after rom_addr is sampled
//            video_hs/vs - syncs, active level set by SYNC_POL
//            video_de    - active video
//            video_rgb   - {R,G,B}, 8 bits each, zero outside active video
//            frame_start - one-clock pulse on the first output cycle of a frame
// Revision : 1.0 - initial release
// ============================================================================
module video_pattern_gen #(
  parameter int   H_SYNC   = 44,
  parameter int   H_BACK   = 148,
  parameter int   H_DISP   = 1920,
  parameter int   H_FRONT  = 88,
  parameter int   V_SYNC   = 5,
  parameter int   V_BACK   = 36,
  parameter int   V_DISP   = 1080,
  parameter int   V_FRONT  = 4,
  parameter logic SYNC_POL = 1'b1,
  parameter int   BAR_NUM  = 8,
  parameter int   IMG_X    = 0,
  parameter int   IMG_Y    = 0,
  parameter int   IMG_W    = 192,
  parameter int   IMG_H    = 128,
  parameter int   CW       = 2,
  parameter int   ROM_AW   = 15
) (
  input  logic              pixel_clk,
  input  logic              sys_rst_n,
  input  logic [1:0]        mode,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [3*CW-1:0]   rom_data,
  output logic              video_hs,
  output logic              video_vs,
  output logic              video_de,
  output logic [23:0]       video_rgb,
  output logic              frame_start
);

  localparam logic [11:0] H_LAST   = 12'(H_SYNC + H_BACK + H_DISP + H_FRONT - 1);
  localparam logic [11:0] V_LAST   = 12'(V_SYNC + V_BACK + V_DISP + V_FRONT - 1);
  localparam logic [11:0] H_ACT0   = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] V_ACT0   = 12'(V_SYNC + V_BACK);
  localparam logic [11:0] H_SYNC_C = 12'(H_SYNC);
  localparam logic [11:0] V_SYNC_C = 12'(V_SYNC);
  localparam logic [11:0] H_DISP_C = 12'(H_DISP);
  localparam logic [11:0] V_DISP_C = 12'(V_DISP);
  localparam logic [11:0] IMG_X_C  = 12'(IMG_X);
  localparam logic [11:0] IMG_Y_C  = 12'(IMG_Y);
  localparam logic [11:0] IMG_W_C  = 12'(IMG_W);
  localparam logic [11:0] IMG_H_C  = 12'(IMG_H);
  localparam logic [11:0] BAR_W_M1 = 12'(H_DISP / BAR_NUM - 1);
  localparam logic [11:0] BAR_LAST = 12'(BAR_NUM - 1);

  // --------------------------------------------------------------------------
  // Raster counters (S0)
  // --------------------------------------------------------------------------
  logic [11:0] h_cnt;
  logic [11:0] v_cnt;

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_cnt <= 12'd0;
      v_cnt <= 12'd0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= 12'd0;
      v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  // Active coordinates use modulo-4096 subtraction: positions left of / above
  // the active area wrap to large values, so a single unsigned compare gives
  // the whole range check.
  logic [11:0] x;
  logic [11:0] y;
  logic [11:0] win_x;
  logic [11:0] win_y;
  logic        h_act;
  logic        de0;
  logic        hs0;
  logic        vs0;
  logic        frame0;
  logic        in_win0;
  logic        grid0;
  logic [1:0]  mode_sel;
  logic [1:0]  mode_r;

  assign x        = h_cnt - H_ACT0;
  assign y        = v_cnt - V_ACT0;
  assign win_x    = x - IMG_X_C;
  assign win_y    = y - IMG_Y_C;
  assign h_act    = (x < H_DISP_C);
  assign de0      = h_act && (y < V_DISP_C);
  assign hs0      = (h_cnt < H_SYNC_C);
  assign vs0      = (v_cnt < V_SYNC_C);
  assign frame0   = (h_cnt == 12'd0) && (v_cnt == 12'd0);
  assign in_win0  = de0 && (win_x < IMG_W_C) && (win_y < IMG_H_C);
  assign grid0    = (x[5:0] == 6'd0) || (y[5:0] == 6'd0);
  // The frame's first cycle already uses the newly sampled mode.
  assign mode_sel = frame0 ? mode : mode_r;

  // --------------------------------------------------------------------------
  // Bar index: a position counter inside the current bar steps the index at
  // each bar boundary; the last bar never advances so it absorbs the remainder.
  // Both clear whenever the line is outside the active span.
  // --------------------------------------------------------------------------
  logic [11:0] bar_pos;
  logic [11:0] bar_idx;

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bar_pos <= 12'd0;
      bar_idx <= 12'd0;
    end else if (!h_act) begin
      bar_pos <= 12'd0;
      bar_idx <= 12'd0;
    end else if ((bar_pos == BAR_W_M1) && (bar_idx != BAR_LAST)) begin
      bar_pos <= 12'd0;
      bar_idx <= bar_idx + 12'd1;
    end else begin
      bar_pos <= bar_pos + 12'd1;
    end
  end

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = 24'hFFFFFF;
      3'd1:    bar_colour = 24'hFFFF00;
      3'd2:    bar_colour = 24'h00FFFF;
      3'd3:    bar_colour = 24'h00FF00;
      3'd4:    bar_colour = 24'hFF00FF;
      3'd5:    bar_colour = 24'hFF0000;
      3'd6:    bar_colour = 24'h0000FF;
      default: bar_colour = 24'h000000;
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // Frame mode latch and ROM address counter
  // --------------------------------------------------------------------------
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_r   <= 2'd0;
      rom_addr <= '0;
    end else begin
      mode_r <= mode_sel;
      if (frame0) begin
        rom_addr <= '0;
      end else if (in_win0) begin
        rom_addr <= rom_addr + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // S1: carry everything that must meet rom_data one clock later
  // --------------------------------------------------------------------------
  logic        hs1;
  logic        vs1;
  logic        de1;
  logic        win1;
  logic        grid1;
  logic        fs1;
  logic [1:0]  mode1;
  logic [23:0] bar1;

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hs1   <= 1'b0;
      vs1   <= 1'b0;
      de1   <= 1'b0;
      win1  <= 1'b0;
      grid1 <= 1'b0;
      fs1   <= 1'b0;
      mode1 <= 2'd0;
      bar1  <= 24'd0;
    end else begin
      hs1   <= hs0;
      vs1   <= vs0;
      de1   <= de0;
      win1  <= in_win0;
      grid1 <= grid0;
      fs1   <= frame0;
      mode1 <= mode_sel;
      bar1  <= bar_colour(bar_idx[2:0]);
    end
  end

  // --------------------------------------------------------------------------
  // Component expansion: output bit 7-i takes component bit CW-1-(i mod CW),
  // i.e. the component is repeated MSB-first until 8 bits are filled.
  // --------------------------------------------------------------------------
  logic [7:0] bmp_r;
  logic [7:0] bmp_g;
  logic [7:0] bmp_b;

  generate
    for (genvar i = 0; i < 8; i++) begin : g_expand
      assign bmp_r[7-i] = rom_data[2*CW + CW - 1 - (i % CW)];
      assign bmp_g[7-i] = rom_data[CW + CW - 1 - (i % CW)];
      assign bmp_b[7-i] = rom_data[CW - 1 - (i % CW)];
    end
  endgenerate

  logic [23:0] pix;

  always_comb begin
    pix = 24'd0;
    if (de1) begin
      case (mode1)
        2'd0:    pix = bar1;
        2'd1:    pix = win1 ? {bmp_r, bmp_g, bmp_b} : 24'd0;
        2'd2:    pix = win1 ? {bmp_r, bmp_g, bmp_b} : bar1;
        default: pix = grid1 ? 24'hFFFFFF : 24'd0;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // S2: output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      video_hs    <= ~SYNC_POL;
      video_vs    <= ~SYNC_POL;
      video_de    <= 1'b0;
      video_rgb   <= 24'd0;
      frame_start <= 1'b0;
    end else begin
      video_hs    <= hs1 ? SYNC_POL : ~SYNC_POL;
      video_vs    <= vs1 ? SYNC_POL : ~SYNC_POL;
      video_de    <= de1;
      video_rgb   <= pix;
      frame_start <= fs1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_video_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_pattern_gen
// Purpose  : Self-checking bench for video_pattern_gen on a small raster
//            (22 x 7). Expected outputs are computed from the absolute cycle
//            number after reset release using frame arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_pattern_gen;

  localparam int HT = 22;
  localparam int VT = 7;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [14:0] rom_addr;
  logic [5:0]  rom_q = 6'd0;
  logic        video_hs;
  logic        video_vs;
  logic        video_de;
  logic [23:0] video_rgb;
  logic        frame_start;

  logic [5:0] rom_tab [16];
  logic [1:0] mode_at [4096];
  int total = 0;
  int bad   = 0;
  int k     = 0;

  video_pattern_gen #(
    .H_SYNC(2), .H_BACK(2), .H_DISP(16), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1),
    .SYNC_POL(1'b1), .BAR_NUM(3),
    .IMG_X(6), .IMG_Y(1), .IMG_W(4), .IMG_H(2),
    .CW(2), .ROM_AW(15)
  ) dut (
    .pixel_clk(clk),
    .sys_rst_n(rst_n),
    .mode(mode),
    .rom_addr(rom_addr),
    .rom_data(rom_q),
    .video_hs(video_hs),
    .video_vs(video_vs),
    .video_de(video_de),
    .video_rgb(video_rgb),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: q valid one clock after the address is sampled.
  always @(posedge clk) rom_q <= rom_tab[rom_addr[3:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp_v);
    end
  endtask

  function automatic bit in_win(input int x, input int y);
    return (x >= 6) && (x < 10) && (y >= 1) && (y < 3);
  endfunction

  function automatic logic [23:0] bar_rgb(input int x);
    int b;
    b = x / 5;
    if (b > 2) b = 2;
    case (b)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      default: return 24'h00FFFF;
    endcase
  endfunction

  function automatic logic [23:0] bmp_rgb(input int x, input int y);
    logic [5:0] q;
    q = rom_tab[(y - 1) * 4 + (x - 6)];
    return {8'(int'(q[5:4]) * 85), 8'(int'(q[3:2]) * 85), 8'(int'(q[1:0]) * 85)};
  endfunction

  // Address held by the ROM counter after edge kk: number of window pixels
  // already passed in the current frame (whole previous frame at position 0).
  function automatic int exp_addr(input int kk);
    int p;
    int cnt;
    if (kk == 0) return 0;
    p = kk % FT;
    if (p == 0) return 8;
    cnt = 0;
    for (int q = 0; q < p; q++) begin
      if (in_win(q % HT - 4, q / HT - 2)) cnt++;
    end
    return cnt;
  endfunction

  task automatic check_out();
    logic        e_hs, e_vs, e_de, e_fs;
    logic [23:0] e_rgb;
    int n, p, x, y;
    logic [1:0] fm;
    e_hs = 1'b0; e_vs = 1'b0; e_de = 1'b0; e_fs = 1'b0; e_rgb = 24'd0;
    if (k >= 2) begin
      n  = k - 2;
      p  = n % FT;
      x  = p % HT - 4;
      y  = p / HT - 2;
      fm = mode_at[(n / FT) * FT + 1];
      e_hs = (p % HT) < 2;
      e_vs = (p / HT) < 1;
      e_de = (x >= 0) && (x < 16) && (y >= 0) && (y < 4);
      e_fs = (p == 0);
      if (e_de) begin
        case (fm)
          2'd0: e_rgb = bar_rgb(x);
          2'd1: e_rgb = in_win(x, y) ? bmp_rgb(x, y) : 24'h000000;
          2'd2: e_rgb = in_win(x, y) ? bmp_rgb(x, y) : bar_rgb(x);
          default: e_rgb = ((x % 64 == 0) || (y % 64 == 0)) ? 24'hFFFFFF : 24'h000000;
        endcase
      end
    end
    chk("hs", 32'(video_hs), 32'(e_hs));
    chk("vs", 32'(video_vs), 32'(e_vs));
    chk("de", 32'(video_de), 32'(e_de));
    chk("rgb", 32'(video_rgb), 32'(e_rgb));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("rom_addr", 32'(rom_addr), 32'(exp_addr(k)));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_hs"}, 32'(video_hs), 32'(0));
    chk({tag, "_vs"}, 32'(video_vs), 32'(0));
    chk({tag, "_de"}, 32'(video_de), 32'(0));
    chk({tag, "_rgb"}, 32'(video_rgb), 32'(0));
    chk({tag, "_fs"}, 32'(frame_start), 32'(0));
    chk({tag, "_addr"}, 32'(rom_addr), 32'(0));
  endtask

  task automatic step();
    @(posedge clk);
    k++;
    mode_at[k] = mode;
    @(negedge clk);
    check_out();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom_tab[i] = 6'b110100;

    // Power-on reset held across a clock edge.
    @(posedge clk);
    @(negedge clk);
    check_reset("por");
    rst_n = 1'b1;
    k = 0;

    // Frame 0 bars; switch to grid mid-frame (frame 1), then bitmap (frame 2),
    // then bitmap over bars (frame 3).
    run(77);
    mode = 2'd3;
    run(154);
    mode = 2'd1;
    run(154);
    mode = 2'd2;
    run(154);
    mode = 2'd0;
    run(43);

    // Randomised frames: new ROM contents and mode chosen after the window.
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 16; i++) rom_tab[i] = 6'($urandom_range(0, 63));
      mode = 2'($urandom_range(0, 3));
      run(154);
    end

    // Reach h_cnt=10, v_cnt=3 and reset asynchronously.
    run(110);
    #2 rst_n = 1'b0;
    #1 check_reset("async");
    @(posedge clk);
    @(negedge clk);
    check_reset("held");
    mode = 2'($urandom_range(0, 3));
    rst_n = 1'b1;
    k = 0;
    run(2 * 154 + 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
